// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
package seven_seg_pkg;

    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned MIW        = $clog2(MAX_DIGITS);

    // All segments dark (segments are active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // Leading-zero blank mask: digit i>0 is blanked when it and every
    // higher digit hold zero. Digit 0 always stays visible.
    function automatic logic [MAX_DIGITS-1:0] blank_mask(
        input logic [4*MAX_DIGITS-1:0] val,
        input int unsigned             num_digits,
        input logic                    blank_lz
    );
        logic [MAX_DIGITS-1:0] m;
        logic                  all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int unsigned i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < num_digits) begin
                all_zero = all_zero && (val[4*i +: 4] == 4'h0);
                m[i]     = blank_lz && all_zero;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_decode.sv
// Combinational nibble-to-glyph decoder; optionally suppresses A-F.
module seg7_glyph_decode
    import seven_seg_pkg::*;
#(
    parameter int HEX_EN = 1
) (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_glyph
);

    // Table lookup, with nibbles above 9 forced dark when hex is disabled.
    always_comb begin
        o_glyph = GLYPH[i_nibble];
        if ((HEX_EN == 0) && (i_nibble > 4'd9)) begin
            o_glyph = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with double-buffered
// value, leading-zero blanking, brightness PWM and inter-digit guard time.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 100000,
    parameter int GUARD        = 200,
    parameter int HEX_EN       = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [2:0]              bright,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned OW = 40;

    localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [OW-1:0] USABLE    = OW'(DIGIT_CYCLES - GUARD);
    localparam logic [OW-1:0] GUARD_W   = OW'(GUARD);

    logic [CW-1:0]           r_slot_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow_val;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    logic                    w_slot_last;
    logic                    w_wrap;
    logic [3:0]              w_nib;
    logic                    w_dp_bit;
    logic [6:0]              w_glyph;
    logic [4*MAX_DIGITS-1:0] w_val_ext;
    logic [MAX_DIGITS-1:0]   w_mask;
    logic                    w_blank_sel;
    logic [OW-1:0]           w_on_len;
    logic [OW-1:0]           w_slot_w;
    logic                    w_in_win;
    logic                    w_lit;

    assign w_slot_last = (r_slot_cnt == SLOT_LAST);
    assign w_wrap      = w_slot_last && (r_idx == IDX_LAST);

    // Slot counter and digit index; index advances when the slot wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot_cnt <= '0;
            r_idx      <= '0;
        end else if (w_slot_last) begin
            r_slot_cnt <= '0;
            r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    // Shadow takes every load; display copies the pre-edge shadow at the
    // frame wrap, so a load on the wrap cycle lands one frame later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
        end else begin
            if (load) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp_in;
            end
            if (w_wrap) begin
                r_disp_val <= r_shadow_val;
                r_disp_dp  <= r_shadow_dp;
            end
        end
    end

    // Select the nibble and decimal point of the digit currently scanned.
    always_comb begin
        w_nib    = '0;
        w_dp_bit = 1'b0;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (r_idx == IW'(d)) begin
                w_nib    = r_disp_val[4*d +: 4];
                w_dp_bit = r_disp_dp[d];
            end
        end
    end

    assign w_val_ext   = (4*MAX_DIGITS)'(r_disp_val);
    assign w_mask      = blank_mask(w_val_ext, NUM_DIGITS, blank_lz);
    assign w_blank_sel = w_mask[MIW'(r_idx)];

    seg7_glyph_decode #(
        .HEX_EN (HEX_EN)
    ) u_decode (
        .i_nibble (w_nib),
        .o_glyph  (w_glyph)
    );

    // PWM window: full-width product before the divide-by-8.
    assign w_on_len = (USABLE * (OW'(bright) + OW'(1))) >> 3;
    assign w_slot_w = OW'(r_slot_cnt);
    assign w_in_win = (w_slot_w >= GUARD_W) && (w_slot_w < (GUARD_W + w_on_len));
    assign w_lit    = w_in_win && !w_blank_sel;

    // Registered outputs; segments and dp go dark whenever no anode is on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_lit) begin
                r_an  <= ~(NUM_DIGITS'(1) << r_idx);
                r_seg <= w_glyph;
                r_dp  <= ~w_dp_bit;
            end else begin
                r_an  <= '1;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver (4 digits, 16-cycle slots, guard 2).
module tb_seven_seg_scan_driver;

    localparam int ND = 4;
    localparam int DC = 16;
    localparam int G  = 2;
    localparam int FR = ND * DC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [2:0]  bright;

    logic [6:0]  seg, seg_h0;
    logic        dp, dp_h0;
    logic [3:0]  an, an_h0;
    logic        fd, fd_h0;

    int checks   = 0;
    int failures = 0;

    logic [3:0] cap_an  [FR];
    logic [6:0] cap_seg [FR];
    logic       cap_dp  [FR];
    logic       cap_fd  [FR];
    logic [3:0] cap_an0 [FR];
    logic [6:0] cap_seg0[FR];

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .DIGIT_CYCLES (DC),
        .GUARD        (G),
        .HEX_EN       (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .bright     (bright),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (fd)
    );

    seven_seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .DIGIT_CYCLES (DC),
        .GUARD        (G),
        .HEX_EN       (0)
    ) dut_h0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .bright     (bright),
        .seg        (seg_h0),
        .dp         (dp_h0),
        .an         (an_h0),
        .frame_done (fd_h0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record one full frame of outputs (64 edges, last one is the wrap).
    task automatic capture_frame();
        for (int k = 0; k < FR; k++) begin
            tick();
            cap_an[k]   = an;
            cap_seg[k]  = seg;
            cap_dp[k]   = dp;
            cap_fd[k]   = fd;
            cap_an0[k]  = an_h0;
            cap_seg0[k] = seg_h0;
        end
    endtask

    task automatic wait_fd(input int max, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max && !ok; k++) begin
            tick();
            if (fd) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int first_an, first_fd;
        rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0;
        blank_lz = 1'b0; bright = 3'd7;
        repeat (3) tick();
        checks++;
        if (seg !== 7'h7F || dp !== 1'b1) begin
            failures++;
            $display("FAIL reset_seg seg=%b dp=%b expected seg=1111111 dp=1", seg, dp);
        end
        checks++;
        if (an !== 4'hF || fd !== 1'b0) begin
            failures++;
            $display("FAIL reset_an an=%h fd=%b expected an=f fd=0", an, fd);
        end
        rst_n = 1'b1;
        first_an = -1;
        first_fd = -1;
        for (int c = 1; c <= 70; c++) begin
            tick();
            if (an[0] == 1'b0 && first_an < 0) first_an = c;
            if (fd == 1'b1 && first_fd < 0) first_fd = c;
        end
        checks++;
        if (first_an !== 3) begin
            failures++;
            $display("FAIL first_an0 cycle=%0d expected 3", first_an);
        end
        checks++;
        if (first_fd !== 64) begin
            failures++;
            $display("FAIL first_frame_done cycle=%0d expected 64", first_fd);
        end
    endtask

    task automatic test_hex_scan();
        logic [6:0] es [4];
        int         low_cnt [4];
        bit         ok, on;
        int         d, s;
        logic [3:0] ea;
        logic [6:0] eseg;
        logic       edp;
        es = '{7'b0010000, 7'b0001000, 7'b0100100, 7'b1111001};
        low_cnt = '{0, 0, 0, 0};
        value = 16'h12A9; dp_in = 4'b0100; bright = 3'd7; load = 1'b1;
        tick();
        load = 1'b0;
        wait_fd(200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL hex_sync frame_done timeout");
        end
        capture_frame();
        for (int k = 0; k < FR; k++) begin
            d = k / DC; s = k % DC;
            on = (s >= 2);
            ea   = on ? ~(4'b0001 << d) : 4'hF;
            eseg = on ? es[d] : 7'h7F;
            edp  = (on && d == 2) ? 1'b0 : 1'b1;
            checks++;
            if (cap_an[k] !== ea || cap_seg[k] !== eseg || cap_dp[k] !== edp) begin
                failures++;
                $display("FAIL hex_scan k=%0d an=%h seg=%b dp=%b expected an=%h seg=%b dp=%b",
                         k, cap_an[k], cap_seg[k], cap_dp[k], ea, eseg, edp);
            end
            if (on && cap_an[k] === ea) low_cnt[d]++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (low_cnt[i] !== 14) begin
                failures++;
                $display("FAIL hex_low_count digit=%0d got=%0d expected 14", i, low_cnt[i]);
            end
        end
        checks++;
        if (cap_fd[62] !== 1'b0 || cap_fd[63] !== 1'b1 || cap_fd[0] !== 1'b0) begin
            failures++;
            $display("FAIL frame_done_pulse fd62=%b fd63=%b fd0=%b expected 0 1 0",
                     cap_fd[62], cap_fd[63], cap_fd[0]);
        end
        checks++;
        if (cap_an0[21] !== 4'hD || cap_seg0[21] !== 7'h7F) begin
            failures++;
            $display("FAIL hexoff_A an=%h seg=%b expected an=d seg=1111111", cap_an0[21], cap_seg0[21]);
        end
    endtask

    task automatic test_hex_off();
        bit ok;
        value = 16'h0C05; dp_in = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        wait_fd(200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL hexoff_sync frame_done timeout");
        end
        capture_frame();
        checks++;
        if (cap_an0[37] !== 4'hB || cap_seg0[37] !== 7'h7F) begin
            failures++;
            $display("FAIL hexoff_C an=%h seg=%b expected an=b seg=1111111", cap_an0[37], cap_seg0[37]);
        end
        checks++;
        if (cap_an[37] !== 4'hB || cap_seg[37] !== 7'b1000110) begin
            failures++;
            $display("FAIL hexon_C an=%h seg=%b expected an=b seg=1000110", cap_an[37], cap_seg[37]);
        end
        checks++;
        if (cap_seg0[5] !== 7'b0010010 || cap_seg[5] !== 7'b0010010) begin
            failures++;
            $display("FAIL digit_5 seg_h0=%b seg=%b expected 0010010", cap_seg0[5], cap_seg[5]);
        end
    endtask

    task automatic test_blank_lz();
        logic [6:0] es [4];
        bit         ok, on;
        int         d, s;
        logic [3:0] ea;
        logic [6:0] eseg;
        logic       edp;
        es = '{7'b1000000, 7'b1111000, 7'b1000000, 7'b1000000};
        value = 16'h0070; dp_in = 4'b1000; blank_lz = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        wait_fd(200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL blank_sync frame_done timeout");
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) blank_lz = 1'b0;
            capture_frame();
            for (int k = 0; k < FR; k++) begin
                d = k / DC; s = k % DC;
                on = (s >= 2) && (pass == 1 || d < 2);
                ea   = on ? ~(4'b0001 << d) : 4'hF;
                eseg = on ? es[d] : 7'h7F;
                edp  = (on && d == 3) ? 1'b0 : 1'b1;
                checks++;
                if (cap_an[k] !== ea || cap_seg[k] !== eseg || cap_dp[k] !== edp) begin
                    failures++;
                    $display("FAIL blank_lz%0d k=%0d an=%h seg=%b dp=%b expected an=%h seg=%b dp=%b",
                             1 - pass, k, cap_an[k], cap_seg[k], cap_dp[k], ea, eseg, edp);
                end
            end
        end
    endtask

    task automatic test_bright();
        bit         ok, on;
        int         d, s, len;
        logic [3:0] ea;
        for (int pass = 0; pass < 2; pass++) begin
            bright = (pass == 0) ? 3'd0 : 3'd3;
            len    = (pass == 0) ? 1 : 7;
            capture_frame();
            for (int k = 0; k < FR; k++) begin
                d = k / DC; s = k % DC;
                on = (s >= 2) && (s < 2 + len);
                ea = on ? ~(4'b0001 << d) : 4'hF;
                checks++;
                if (cap_an[k] !== ea) begin
                    failures++;
                    $display("FAIL bright%0d k=%0d an=%h expected %h", bright, k, cap_an[k], ea);
                end
            end
        end
        bright = 3'd1;
        repeat (6) tick();
        checks++;
        if (an !== 4'hF) begin
            failures++;
            $display("FAIL bright1_closed an=%h expected f", an);
        end
        bright = 3'd7;
        tick();
        checks++;
        if (an !== 4'hE) begin
            failures++;
            $display("FAIL bright_midslot an=%h expected e", an);
        end
        wait_fd(200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bright_sync frame_done timeout");
        end
    endtask

    task automatic test_load_on_wrap();
        repeat (FR - 1) tick();
        value = 16'h12A9; dp_in = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (fd !== 1'b1) begin
            failures++;
            $display("FAIL wrap_align fd=%b expected 1", fd);
        end
        capture_frame();
        checks++;
        if (cap_seg[5] !== 7'b1000000 || cap_seg[21] !== 7'b1111000) begin
            failures++;
            $display("FAIL wrap_old seg0=%b seg1=%b expected 1000000 1111000", cap_seg[5], cap_seg[21]);
        end
        capture_frame();
        checks++;
        if (cap_seg[5] !== 7'b0010000 || cap_seg[21] !== 7'b0001000) begin
            failures++;
            $display("FAIL wrap_new seg0=%b seg1=%b expected 0010000 0001000", cap_seg[5], cap_seg[21]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        repeat (5) tick();
        checks++;
        if (an !== 4'hE) begin
            failures++;
            $display("FAIL pre_reset an=%h expected e", an);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || fd !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid an=%h seg=%b dp=%b fd=%b expected f 1111111 1 0", an, seg, dp, fd);
        end
        checks++;
        if (an_h0 !== 4'hF || seg_h0 !== 7'h7F) begin
            failures++;
            $display("FAIL reset_mid_h0 an=%h seg=%b expected f 1111111", an_h0, seg_h0);
        end
        rst_n = 1'b1;
        blank_lz = 1'b1;
        wait_fd(100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reset_mid_sync frame_done timeout");
        end
        capture_frame();
        checks++;
        if (cap_seg[5] !== 7'b1000000 || cap_an[5] !== 4'hE || cap_an[21] !== 4'hF) begin
            failures++;
            $display("FAIL shadow_cleared seg0=%b an0=%h an1=%h expected 1000000 e f",
                     cap_seg[5], cap_an[5], cap_an[21]);
        end
    endtask

    // Never more than one anode low across the whole run.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && $countones(~an) > 1) begin
            checks++;
            failures++;
            $display("FAIL onehot_an an=%h", an);
        end
    end

    initial begin
        test_reset();
        test_hex_scan();
        test_hex_off();
        test_blank_lz();
        test_bright();
        test_load_on_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Time-multiplexed driver for an N-digit common-anode 7-segment display on the Spartan-7 board. Takes a packed nibble-per-digit value and per-digit decimal points, scans one digit at a time with active-low anode and segment outputs, and supports hex/BCD decode, leading-zero blanking, brightness PWM and an inter-digit ghosting guard. New values are double-buffered and take effect only at a frame boundary, so the display never tears.

## Interface
Parameters:
- NUM_DIGITS, 4, digits scanned (2..8)
- DIGIT_CYCLES, 100000, clock cycles per digit slot (>= GUARD+8)
- GUARD, 200, cycles at slot start with all anodes off
- HEX_EN, 1, 1: nibbles A–F shown as hex glyphs; 0: nibbles >9 blanked

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- value  in  4*NUM_DIGITS  nibble i drives digit i (digit 0 rightmost, an[0])
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- load  in  1  1-cycle strobe; captures value/dp_in into shadow
- blank_lz  in  1  enable leading-zero blanking
- bright  in  3  brightness, on-time = (bright+1)/8 of usable slot
- seg  out  7  active-low segments, seg[0]=a … seg[6]=g
- dp  out  1  active-low decimal point
- an  out  NUM_DIGITS  active-low anodes, at most one low at any time
- frame_done  out  1  1-cycle pulse when the display register reloads

## Operation
- Reset: seg=7'h7F, dp=1, an=all ones, frame_done=0; slot counter, digit index, shadow and display registers cleared.
- Shadow register: written on any cycle with load=1; last load wins.
- Display register: copied from shadow on the edge where digit index wraps NUM_DIGITS-1→0. frame_done=1 on that same edge. A load on the wrap cycle goes to shadow only and appears the following frame.
- Slot counter: 0..DIGIT_CYCLES-1. On reaching DIGIT_CYCLES-1, it wraps to 0 and the digit index increments modulo NUM_DIGITS.
- on_len = ((DIGIT_CYCLES-GUARD)*(bright+1))>>3, computed at full width with no truncation before the shift. bright is sampled every cycle, so a change takes effect immediately.
- an[idx] is driven low when GUARD <= slot_cnt < GUARD+on_len and the digit is not blanked. Otherwise all anodes are high.
- Decode uses nibble patterns 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000.
  - With HEX_EN=1: A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110.
  - With HEX_EN=0: nibbles >9 give 1111111.
- Leading-zero blanking: with blank_lz=1, digit i>0 is blanked if its nibble and all higher nibbles are 0. Digit 0 is never blanked by this rule. A blanked digit forces an high, seg=7F and dp=1, regardless of dp_in.
- When an is all high, seg and dp are also driven to all-off (1).

## Timing
- All outputs are registered. an, seg and dp reflect the pre-edge slot_cnt and index one clock later.
- The first digit-0 on-window after reset starts with an[0] low at cycle GUARD+1 after rst_n rises.
- The display register loads at the end of the first frame after reset. Until then it shows 0 on digit 0, with higher digits showing 0 or blank depending on blank_lz.
- Latency from a load to visible is at most NUM_DIGITS*DIGIT_CYCLES+1 cycles.
- Reset asserted mid-slot returns all outputs to reset values on the next edge. Shadow contents are discarded.
- Sampling an at any edge gives at most one anode low.

## Structure
- Package seven_seg_pkg: SEG_BLANK=7'h7F, the 16-entry glyph constant array, and the function computing the blank mask from value and blank_lz.
- Sub-module seg7_glyph_decode: combinational nibble + HEX_EN → 7-bit pattern. It is instantiated once and decodes the nibble selected by the current index.
- Top level: slot counter, index counter, shadow/display registers, PWM compare and output registers.

## Test plan
Bench uses NUM_DIGITS=4, DIGIT_CYCLES=16, GUARD=2.
- Reset hold, then release → seg=7F, an=F while rst_n=0; an[0] low first at cycle 3; frame_done first pulses at cycle 64.
- load value=16'h12A9, dp_in=4'b0100, HEX_EN=1, bright=7 → per frame an cycles E,D,B,7 with seg 0010000, 0001000, 0100100, 1111001; dp=0 only while an=B; each anode low for 14 cycles.
- value=16'h0070, blank_lz=1 → digit3 blanked (an[3] never low), digit2 blanked, digit1 seg=1111000, digit0 seg=1000000; with blank_lz=0, digits 3 and 2 show 1000000.
- bright=0 → each on-window is (14*1)>>3 = 1 cycle; bright=3 → 7 cycles; the change is visible within the current slot.
- load on the exact cycle frame_done=1 → old value displayed for one more full frame; new value appears after the next frame_done.
- HEX_EN=0, nibble 4'hC → seg=7F with that anode still scanned; rst_n pulsed low mid-slot → all outputs return to reset values on the next edge.
